// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// Imported by the arbiter, its interface and the zero-extend helper.
package mem_pkg;

   localparam int MEM_ADDR_W = 12;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   typedef enum logic {
      PORT_F = 1'b0,
      PORT_D = 1'b1
   } port_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Memory-side bus of the arbiter: one access in flight, ready-terminated.
// master = arbiter, slave = memory.
interface mem_port_arbiter_if
   import mem_pkg::*;
#(
   parameter int DATA_W = MEM_DATA_W
);

   logic              mem_en;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_en,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_en,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ready,
      output mem_rdata
   );

endinterface

// File: rtl/mem_port_arbiter_addr_zext.sv
// Zero-extends a requester address to the memory address width.
// Upper bits are always zero.
module addr_zext #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]  addr,
   output logic [OUT_W-1:0] zext
);

   assign zext = OUT_W'(addr);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for a fetch and a data port onto one memory port.
// IDLE -> ACCESS (until ready or timeout) -> RESP (one-cycle ack).
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W  = MEM_ADDR_W,
   parameter int DATA_W  = MEM_DATA_W,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic              f_we,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic [DATA_W-1:0] f_wdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              f_ack,
   output logic              d_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   mem_port_arbiter_if.master mem
);

   localparam logic [8:0] TMO = 9'(TIMEOUT);

   state_e            state;
   state_e            state_n;
   port_e             last;
   port_e             sel;
   port_e             win;
   logic [7:0]        cnt;
   logic [8:0]        cnt_inc;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] addr_ext;
   logic              load;
   logic              done;
   logic              tmo;
   logic              in_acc;

   addr_zext #(
      .IN_W  (ADDR_W),
      .OUT_W (DATA_W)
   ) u_zext (
      .addr (addr_q),
      .zext (addr_ext)
   );

   assign cnt_inc = {1'b0, cnt} + 9'd1;
   assign in_acc  = (state == ST_ACCESS);

   // On a tie the port that was not served last gets the grant
   always_comb begin
      win = PORT_F;
      if (f_req && d_req)
         win = (last == PORT_F) ? PORT_D : PORT_F;
      else if (d_req)
         win = PORT_D;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      done    = 1'b0;
      tmo     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (f_req || d_req) begin
               load    = 1'b1;
               state_n = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (mem.mem_ready) begin
               done    = 1'b1;
               state_n = ST_RESP;
            end else if (cnt_inc == TMO) begin
               tmo     = 1'b1;
               state_n = ST_RESP;
            end
         end
         ST_RESP: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         last    <= PORT_F;
         sel     <= PORT_F;
         cnt     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
         err     <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            sel <= win;
            cnt <= '0;
            if (win == PORT_D) begin
               we_q    <= d_we;
               addr_q  <= d_addr;
               wdata_q <= d_wdata;
            end else begin
               we_q    <= f_we;
               addr_q  <= f_addr;
               wdata_q <= f_wdata;
            end
         end else if (in_acc && !mem.mem_ready) begin
            cnt <= cnt_inc[7:0];
         end
         if (done) begin
            rdata <= we_q ? '0 : mem.mem_rdata;
            err   <= 1'b0;
         end
         if (tmo) begin
            rdata <= '0;
            err   <= 1'b1;
         end
         if (state == ST_RESP)
            last <= sel;
      end
   end

   assign f_ack = (state == ST_RESP) && (sel == PORT_F);
   assign d_ack = (state == ST_RESP) && (sel == PORT_D);

   assign mem.mem_en    = in_acc;
   assign mem.mem_we    = in_acc && we_q;
   assign mem.mem_addr  = in_acc ? addr_ext : '0;
   assign mem.mem_wdata = in_acc ? wdata_q : '0;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, requester address width.
REQ-002 Parameter DATA_W, default 32, data and memory-address width.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ready; legal range 1..255.
REQ-004 Port clk, input, 1, single clock; all logic SHALL be rising-edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Ports f_req, f_we, input, 1 each: fetch-port request and write-enable.
REQ-007 Ports f_addr (input, ADDR_W) and f_wdata (input, DATA_W): fetch-port address and write data.
REQ-008 Ports d_req, d_we, d_addr, d_wdata: data port, same widths and meanings as the fetch port.
REQ-009 Ports f_ack, d_ack, output, 1 each: one-cycle completion pulse per port.
REQ-010 Ports rdata (output, DATA_W) and err (output, 1): shared read data and timeout flag, both valid while any ack is high.
REQ-011 Memory-side outputs: mem_en (1), mem_we (1), mem_addr (DATA_W), mem_wdata (DATA_W).
REQ-012 Memory-side inputs: mem_ready (1) and mem_rdata (DATA_W).

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-014 IDLE: if either request is high, the block SHALL latch the winner's addr/we/wdata and go to ACCESS the next cycle; otherwise it stays in IDLE.
REQ-015 Arbitration SHALL be round-robin; on simultaneous requests the port not served last wins; after reset the data port wins the first tie.
REQ-016 mem_addr SHALL be the latched address zero-extended, i.e. upper DATA_W-ADDR_W bits 0 and lower bits equal to the address.
REQ-017 In ACCESS, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL hold the latched values; in all other states they SHALL be 0.
REQ-018 In ACCESS with mem_ready=1, the block SHALL register mem_rdata into rdata (writes register 0), clear err, and go to RESP.
REQ-019 A wait counter SHALL clear on ACCESS entry and increment each ACCESS cycle without mem_ready.
REQ-020 When the counter reaches TIMEOUT, the block SHALL go to RESP with err=1 and rdata=0.
REQ-021 mem_ready on the same cycle as the timeout SHALL take precedence: normal completion, err=0.
REQ-022 RESP SHALL last exactly one cycle: assert the winner's ack, update the last-served pointer, then return to IDLE.
REQ-023 Requests SHALL be ignored in ACCESS and RESP; no request is ever lost or reordered.
REQ-024 A requester SHALL hold req and its operands until its ack and drop req the cycle after ack unless it has a new request.
REQ-025 Best-case latency from req high in IDLE to ack SHALL be 3 cycles (IDLE, ACCESS with mem_ready=1, RESP).
REQ-026 rdata and err SHALL hold their values until the next RESP.

Reset
REQ-027 On rst_n low, the block SHALL asynchronously force: state IDLE, counter 0, last-served pointer to fetch, and all outputs 0 (including rdata and err).
REQ-028 Reset asserted mid-ACCESS SHALL abort the transfer with no ack issued; the requester SHALL re-request after reset.

Structure
REQ-029 State encoding and the default ADDR_W/DATA_W constants SHALL live in the shared package mem_pkg.
REQ-030 Zero-extension SHALL be a single sub-module instance, addr_zext (ADDR_W to DATA_W), shared with the datapath.

Verification
REQ-031 Fetch read: f_req, f_addr=12'hABC, mem_ready high on the first ACCESS cycle -> mem_addr=32'h00000ABC, f_ack 3 cycles after req, rdata = mem_rdata.
REQ-032 Simultaneous requests after reset -> d served first, then f; a second tie -> d served first (last-served was f); each port gets exactly one ack per request.
REQ-033 Data write: d_we=1, d_addr=12'hFFF, d_wdata=32'h12345678 -> mem_addr=32'h00000FFF, mem_we=1, mem_wdata=32'h12345678, d_ack with rdata=0.
REQ-034 mem_ready held low -> err=1 and ack exactly TIMEOUT ACCESS cycles later; mem_ready rising on the TIMEOUT cycle -> err=0.
REQ-035 rst_n pulsed low in ACCESS -> all outputs 0 immediately, no ack, IDLE after release; the next request completes normally.
